// File: rtl/rm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rm_pkg
//  Description : Shared definitions for the runtime-monitor symbol interface.
//                Holds the symbol width used by the feeder and the monitor
//                cluster tops, and the feeder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rm_pkg;

    // Symbol width shared with the monitor cluster tops (cluster3lw, ...)
    localparam int RM_SYM_W = 8;

    // Feeder state: automata held in reset, or symbols streaming
    typedef enum logic [0:0] {
        MRST   = 1'b0,
        STREAM = 1'b1
    } feeder_state_e;

endpackage : rm_pkg
`default_nettype wire

// File: rtl/rm_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rm_sync_fifo
//  Description : Single-clock FIFO buffering trace symbols. Occupancy is kept
//                as an explicit count; full/empty are derived from it so the
//                pointers can simply wrap. flush_i clears pointers and count.
//  Ports       : clk, reset_n      clock, asynchronous active-low reset
//                flush_i           discard all contents (takes priority)
//                push_i/wr_data_i  write request and data (ignored when full)
//                pop_i/rd_data_o   read request and head-of-queue data
//                count_o           occupancy 0..DEPTH
//                full_o/empty_o    occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module rm_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int SYM_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [SYM_W-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [SYM_W-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o    = (count_q == C_DEPTH);
    assign empty_o   = (count_q == '0);
    assign w_push    = push_i & ~full_o & ~flush_i;
    assign w_pop     = pop_i & ~empty_o & ~flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset: contents are only visible through count_q
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule : rm_sync_fifo
`default_nettype wire

// File: rtl/rm_symbol_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : rm_symbol_feeder
//  Description : Transmit side of the runtime-monitor symbol interface.
//                Buffers bursty trace symbols and drives a one-symbol-per-
//                cycle stream (symbols/run) plus the automata reset
//                (mon_reset) to the monitor cluster tops. Sequences the
//                automata reset after power-up and on flush.
//  Ports       : clk, reset_n          clock, asynchronous active-low reset
//                evt_valid/evt_symbol  upstream symbol offer
//                evt_ready             accept (transfer on valid & ready)
//                enable                1 = stream, 0 = hold buffered symbols
//                flush                 discard buffer, restart automata reset
//                symbols/run           registered symbol stream to monitors
//                mon_reset             registered active-high automata reset
//                fifo_count            buffer occupancy
//                stall_cnt             saturating count of refused offers
//  Revision    : 1.0 - initial release
// ============================================================================
module rm_symbol_feeder
    import rm_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SYM_W      = RM_SYM_W,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     evt_valid,
    input  logic [SYM_W-1:0]         evt_symbol,
    output logic                     evt_ready,
    input  logic                     enable,
    input  logic                     flush,
    output logic [SYM_W-1:0]         symbols,
    output logic                     run,
    output logic                     mon_reset,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] C_RLAST = RC_W'(RST_CYCLES - 1);

    feeder_state_e    state_q, state_d;
    logic [RC_W-1:0]  rst_ctr_q, rst_ctr_d;
    logic             s1_valid_q;
    logic [SYM_W-1:0] s1_sym_q, s1_sym_d;
    logic [SYM_W-1:0] symbols_q, symbols_d;
    logic             run_q, run_d;
    logic             mon_reset_q, mon_reset_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [SYM_W-1:0] w_head;

    // The flush cycle refuses offers so the handshake never reports a
    // transfer that the cleared buffer would silently drop.
    assign evt_ready = (state_q == STREAM) & ~w_full & ~flush;
    assign w_push    = evt_valid & evt_ready;
    assign w_pop     = (state_q == STREAM) & enable & ~w_empty & ~flush;

    rm_sync_fifo #(
        .DEPTH (DEPTH),
        .SYM_W (SYM_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (flush),
        .push_i    (w_push),
        .wr_data_i (evt_symbol),
        .pop_i     (w_pop),
        .rd_data_o (w_head),
        .count_o   (fifo_count),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    // Reset sequencer: stay in MRST for RST_CYCLES clocks, restart on flush
    always_comb begin
        state_d   = state_q;
        rst_ctr_d = rst_ctr_q;
        if (flush) begin
            state_d   = MRST;
            rst_ctr_d = '0;
        end else if (state_q == MRST) begin
            if (rst_ctr_q == C_RLAST) begin
                state_d   = STREAM;
                rst_ctr_d = '0;
            end else begin
                rst_ctr_d = rst_ctr_q + 1'b1;
            end
        end
    end

    // Two-stage output path: the popped head is captured first, then
    // presented on the registered symbol port. A flush kills both stages.
    always_comb begin
        s1_sym_d    = w_pop ? w_head : s1_sym_q;
        run_d       = s1_valid_q & ~flush;
        symbols_d   = run_d ? s1_sym_q : '0;
        mon_reset_d = (state_d == MRST);
    end

    always_comb begin
        stall_d = stall_q;
        if (evt_valid && !evt_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MRST;
            rst_ctr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_sym_q    <= '0;
            symbols_q   <= '0;
            run_q       <= 1'b0;
            mon_reset_q <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            rst_ctr_q   <= rst_ctr_d;
            s1_valid_q  <= w_pop;
            s1_sym_q    <= s1_sym_d;
            symbols_q   <= symbols_d;
            run_q       <= run_d;
            mon_reset_q <= mon_reset_d;
            stall_q     <= stall_d;
        end
    end

    assign symbols   = symbols_q;
    assign run       = run_q;
    assign mon_reset = mon_reset_q;
    assign stall_cnt = stall_q;

endmodule : rm_symbol_feeder
`default_nettype wire

// File: tb/tb_rm_symbol_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rm_symbol_feeder
//  Description : Self-checking bench for rm_symbol_feeder. A queue-based
//                reference model tracks buffer contents, reset sequencing,
//                output latency and the stall counter; directed sequences
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rm_symbol_feeder;

    localparam int DEPTH      = 8;
    localparam int SYM_W      = 8;
    localparam int RST_CYCLES = 2;
    localparam int CNT_W      = 16;
    localparam int STALL_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              evt_valid = 1'b0;
    logic [SYM_W-1:0]  evt_symbol = '0;
    logic              evt_ready;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic [SYM_W-1:0]  symbols;
    logic              run;
    logic              mon_reset;
    logic [3:0]        fifo_count;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [SYM_W-1:0] m_q[$];
    logic [SYM_W-1:0] got_q[$];
    int               m_mrst     = RST_CYCLES;
    bit               m_pend     = 1'b0;
    logic [SYM_W-1:0] m_pend_sym = '0;
    bit               m_run      = 1'b0;
    logic [SYM_W-1:0] m_sym      = '0;
    int               m_stall    = 0;

    rm_symbol_feeder #(
        .DEPTH      (DEPTH),
        .SYM_W      (SYM_W),
        .RST_CYCLES (RST_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .evt_valid  (evt_valid),
        .evt_symbol (evt_symbol),
        .evt_ready  (evt_ready),
        .enable     (enable),
        .flush      (flush),
        .symbols    (symbols),
        .run        (run),
        .mon_reset  (mon_reset),
        .fifo_count (fifo_count),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_mrst     = RST_CYCLES;
        m_pend     = 1'b0;
        m_pend_sym = '0;
        m_run      = 1'b0;
        m_sym      = '0;
        m_stall    = 0;
    endtask

    // Model: a symbol popped at one edge is shown after the following edge;
    // the automata reset lasts RST_CYCLES edges after reset/flush.
    always @(posedge clk or negedge reset_n) begin
        bit ready_e;
        bit pop_e;
        if (!reset_n) begin
            m_reset();
        end else begin
            ready_e = (m_mrst == 0) && (m_q.size() < DEPTH) && !flush;
            pop_e   = (m_mrst == 0) && enable && (m_q.size() > 0) && !flush;
            if (evt_valid && !ready_e && m_stall != STALL_MAX) m_stall++;
            if (flush) begin
                m_q.delete();
                m_mrst = RST_CYCLES;
                m_pend = 1'b0;
                m_run  = 1'b0;
                m_sym  = '0;
            end else begin
                m_run  = m_pend;
                m_sym  = m_pend ? m_pend_sym : '0;
                m_pend = 1'b0;
                if (pop_e) begin
                    m_pend     = 1'b1;
                    m_pend_sym = m_q.pop_front();
                end
                if (evt_valid && ready_e) m_q.push_back(evt_symbol);
                if (m_mrst > 0) m_mrst--;
            end
            #1;
            check("symbols",    32'(symbols),    32'(m_sym));
            check("run",        32'(run),        32'(m_run));
            check("mon_reset",  32'(mon_reset),  32'(m_mrst > 0));
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("stall_cnt",  32'(stall_cnt),  32'(m_stall));
            check("evt_ready",  32'(evt_ready),
                  32'((m_mrst == 0) && (m_q.size() < DEPTH) && !flush));
            if (run === 1'b1) got_q.push_back(symbols);
        end
    end

    // Offer one symbol and hold it until accepted (bounded wait)
    task automatic send(input logic [SYM_W-1:0] s);
        int n = 0;
        evt_valid  = 1'b1;
        evt_symbol = s;
        while (evt_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(evt_ready), 32'd1);
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_symbols",   32'(symbols),    32'd0);
        check("rst_run",       32'(run),        32'd0);
        check("rst_mon_reset", 32'(mon_reset),  32'd1);
        check("rst_ready",     32'(evt_ready),  32'd0);
        check("rst_count",     32'(fifo_count), 32'd0);
        check("rst_stall",     32'(stall_cnt),  32'd0);

        // ---- reset release; one offer refused during MRST ----
        evt_valid  = 1'b1;
        evt_symbol = 8'hEE;
        reset_n    = 1'b1;
        @(negedge clk);
        check("mrst1_mon_reset", 32'(mon_reset), 32'd1);
        check("mrst1_ready",     32'(evt_ready), 32'd0);
        check("mrst1_stall",     32'(stall_cnt), 32'd1);
        evt_valid = 1'b0;
        @(negedge clk);
        check("stream_mon_reset", 32'(mon_reset), 32'd0);
        check("stream_ready",     32'(evt_ready), 32'd1);
        check("stream_run",       32'(run),       32'd0);

        // ---- single event latency ----
        enable = 1'b1;
        send(8'h5A);
        @(negedge clk);
        check("lat_e1_run", 32'(run), 32'd0);
        @(negedge clk);
        check("lat_e2_run", 32'(run),     32'd1);
        check("lat_e2_sym", 32'(symbols), 32'h5A);
        @(negedge clk);
        check("lat_e3_run", 32'(run),     32'd0);
        check("lat_e3_sym", 32'(symbols), 32'd0);

        // ---- burst of 12 with enable low, then drain ----
        enable = 1'b0;
        repeat (2) @(negedge clk);
        got_q.delete();
        for (int i = 1; i <= 8; i++) send(8'(i));
        check("burst_count", 32'(fifo_count), 32'd8);
        check("burst_ready", 32'(evt_ready),  32'd0);
        evt_valid  = 1'b1;
        evt_symbol = 8'h09;
        repeat (5) @(negedge clk);
        check("burst_stall", 32'(stall_cnt),  32'd6);
        check("burst_full",  32'(fifo_count), 32'd8);
        enable = 1'b1;
        for (int i = 9; i <= 12; i++) send(8'(i));
        repeat (16) @(negedge clk);
        check("burst_nout", 32'(got_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            check("burst_order", 32'(got_q[i]), 32'(i + 1));

        // ---- continuous push+pop at count 4 ----
        enable = 1'b0;
        repeat (2) @(negedge clk);
        got_q.delete();
        for (int i = 0; i < 4; i++) send(8'(8'h20 + i));
        check("pp_start_count", 32'(fifo_count), 32'd4);
        enable     = 1'b1;
        evt_valid  = 1'b1;
        evt_symbol = 8'h24;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("pp_count", 32'(fifo_count), 32'd4);
            evt_symbol = 8'(8'h25 + k);
        end
        evt_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("pp_nout", 32'(got_q.size()), 32'd24);
        for (int i = 0; i < 24 && i < got_q.size(); i++)
            check("pp_order", 32'(got_q[i]), 32'(8'h20 + i));

        // ---- flush with 5 buffered and an offer in the same cycle ----
        enable = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i));
        check("fl_pre_count", 32'(fifo_count), 32'd5);
        repeat (2) @(negedge clk);
        got_q.delete();
        flush      = 1'b1;
        evt_valid  = 1'b1;
        evt_symbol = 8'h99;
        #1;
        check("fl_ready", 32'(evt_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        evt_valid = 1'b0;
        check("fl_count",      32'(fifo_count), 32'd0);
        check("fl_run",        32'(run),        32'd0);
        check("fl_mon_reset1", 32'(mon_reset),  32'd1);
        @(negedge clk);
        check("fl_mon_reset2", 32'(mon_reset), 32'd1);
        @(negedge clk);
        check("fl_mon_reset3", 32'(mon_reset), 32'd0);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("fl_nout", 32'(got_q.size()), 32'd0);

        // ---- stall counter saturation, then async reset mid-stream ----
        enable = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h60 + i));
        evt_valid  = 1'b1;
        evt_symbol = 8'h68;
        repeat (65540) @(negedge clk);
        check("sat_stall", 32'(stall_cnt), 32'hFFFF);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        #2 reset_n = 1'b0;
        #1;
        check("arst_symbols",   32'(symbols),    32'd0);
        check("arst_run",       32'(run),        32'd0);
        check("arst_mon_reset", 32'(mon_reset),  32'd1);
        check("arst_ready",     32'(evt_ready),  32'd0);
        check("arst_count",     32'(fifo_count), 32'd0);
        check("arst_stall",     32'(stall_cnt),  32'd0);
        @(negedge clk);
        evt_valid = 1'b0;
        enable    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_mon_reset", 32'(mon_reset),  32'd0);
        check("post_count",     32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rm_symbol_feeder
`default_nettype wire
